decryption_pipe: RTL and testbench

- Receiver-side inverse of the 5-stage encryption pipeline. Consumes encrypted bytes plus the matching key byte and recovers plaintext.
- Adds what the encrypter lacks: valid/ready flow control, a stall-able 5-stage pipeline and 32-byte frame tracking.
- Sits directly downstream of the encryption block and feeds the plaintext sink; key source is shared with the encrypter side.

---
 rtl/decryption_pipe.sv | 146 ++++++++++++++
 tb/tb_decryption_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decryption_pipe.sv
// decryption_pipe
//
// Receiver-side inverse of the 5-stage encryption pipeline. Each accepted
// encrypted byte travels with its key byte and sender frame marker through five
// registered stages and leaves as plaintext:
//   d = key ^ rotl5(~rev(rotr5(e)))
// Flow control is a single global stall. Every stage shifts together when
// S5 is empty or downstream is ready. Bubbles are kept in place, not squeezed
// out. Input and output byte counters track 32-byte (FRAME_BYTES) frames.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset; in-flight bytes are dropped
//   in_valid   in   e_data/key/in_last valid this cycle
//   in_ready   out  input accepted this cycle (combinational from out_ready)
//   e_data     in   encrypted byte
//   key        in   key byte paired with e_data
//   in_last    in   sender marks the final byte of a frame
//   out_valid  out  d_data valid
//   out_ready  in   downstream accepts d_data
//   d_data     out  decrypted byte
//   out_last   out  d_data is the last byte of its frame (from the output counter)
//   frame_err  out  sticky: a sender frame marker disagreed with the byte count
//   frame_cnt  out  completed output frames, wraps at 16 bits

module decryption_pipe #(
    parameter int unsigned N           = 8,
    parameter int unsigned FRAME_BYTES = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  e_data,
    input  logic [N-1:0]  key,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  d_data,
    output logic          out_last,
    output logic          frame_err,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned NumStages = 5;
    localparam int unsigned IdxW      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_BYTES - 1);

    // Stage registers; index 0 is S1, index 4 is S5.
    logic [NumStages-1:0] r_vld;
    logic [NumStages-1:0] r_last;
    logic [N-1:0]         r_dat [NumStages];
    logic [N-1:0]         r_key [NumStages];

    logic [IdxW-1:0]      r_in_idx;
    logic [IdxW-1:0]      r_out_idx;
    logic                 r_frame_err;
    logic [15:0]          r_frame_cnt;

    logic                 w_adv;
    logic                 w_accept;
    logic                 w_out_hs;
    logic                 w_in_err;
    logic                 w_out_err;
    logic [N-1:0]         w_s1_dat;
    logic [N-1:0]         w_s2_dat;
    logic [N-1:0]         w_s3_dat;
    logic [N-1:0]         w_s4_dat;
    logic [N-1:0]         w_s5_dat;

    // Per-stage transforms, each feeding the next stage register.
    always_comb begin
        w_s1_dat = {e_data[4:0], e_data[N-1:5]};
        w_s2_dat = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_s2_dat[i] = r_dat[0][N-1-i];
        end
        w_s3_dat = ~r_dat[1];
        w_s4_dat = {r_dat[2][N-6:0], r_dat[2][N-1:N-5]};
        w_s5_dat = r_dat[3] ^ r_key[3];
    end

    always_comb begin
        w_adv    = !r_vld[NumStages-1] || out_ready;
        w_accept = in_valid && w_adv;
        w_out_hs = r_vld[NumStages-1] && out_ready;
        w_in_err = w_accept && (in_last != (r_in_idx == LastIdx));
        // The carried marker re-checked at the output agrees with the input-side
        // check in normal operation; it makes the sticky flag robust to either path.
        w_out_err = w_out_hs && (r_last[NumStages-1] != (r_out_idx == LastIdx));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int i = 0; i < NumStages; i++) begin
                r_dat[i] <= '0;
                r_key[i] <= '0;
            end
        end else if (w_adv) begin
            r_vld    <= {r_vld[NumStages-2:0], in_valid};
            r_last   <= {r_last[NumStages-2:0], in_last};
            r_dat[0] <= w_s1_dat;
            r_dat[1] <= w_s2_dat;
            r_dat[2] <= w_s3_dat;
            r_dat[3] <= w_s4_dat;
            r_dat[4] <= w_s5_dat;
            r_key[0] <= key;
            for (int i = 1; i < NumStages; i++) begin
                r_key[i] <= r_key[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_idx    <= '0;
            r_out_idx   <= '0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // FRAME_BYTES is a power of two, so the counters wrap naturally.
            if (w_accept) begin
                r_in_idx <= r_in_idx + IdxW'(1);
            end
            if (w_out_hs) begin
                r_out_idx <= r_out_idx + IdxW'(1);
                if (r_out_idx == LastIdx) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
            if (w_in_err || w_out_err) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld[NumStages-1];
    assign d_data    = r_dat[NumStages-1];
    assign out_last  = r_vld[NumStages-1] && (r_out_idx == LastIdx);
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_decryption_pipe.sv
// Self-checking bench for decryption_pipe (N=8, FRAME_BYTES=32).
// Expected plaintext comes from the bench's own encrypter model or from
// constants. It is queued when a byte is accepted and compared when the DUT
// hands a byte out.

module tb_decryption_pipe;

    localparam int unsigned N  = 8;
    localparam int unsigned FB = 32;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  e_data;
    logic [7:0]  key;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  d_data;
    logic        out_last;
    logic        frame_err;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t       sb_q[$];
    int         errors     = 0;
    int         checks     = 0;
    int         tb_in_idx  = 0;
    int         fc_model   = 0;
    bit         bp_mode    = 0;
    logic       or_level   = 1'b1;
    logic [3:0] bp_pat     = 4'b1001;
    int         bp_k       = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d     = 8'h00;

    decryption_pipe #(
        .N           (N),
        .FRAME_BYTES (FB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_data    (e_data),
        .key       (key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_data    (d_data),
        .out_last  (out_last),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Encrypter model: inverse of the decrypt transform, step by step.
    function automatic logic [7:0] enc(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] y, z, w, v;
        y = d ^ k;
        z = {y[4:0], y[7:5]};
        w = ~z;
        for (int i = 0; i < 8; i++) v[i] = w[7-i];
        return {v[2:0], v[7:3]};
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] e, input logic [7:0] k, input logic lst,
                        input logic [7:0] exp_d);
        int   waited;
        exp_t item;
        waited   = 0;
        in_valid = 1'b1;
        e_data   = e;
        key      = k;
        in_last  = lst;
        @(negedge clock);
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("accept_wait", 32'(waited < 100), 32'd1);
        item.d    = exp_d;
        item.last = (tb_in_idx == FB - 1);
        sb_q.push_back(item);
        tb_in_idx = (tb_in_idx + 1) % FB;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_auto(input logic [7:0] e, input logic [7:0] k, input logic [7:0] exp_d);
        send(e, k, 1'(tb_in_idx == FB - 1), exp_d);
    endtask

    task automatic send_plain();
        logic [7:0] d, k;
        d = 8'($urandom);
        k = 8'($urandom);
        send_auto(enc(d, k), k, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clock);
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // out_ready driver: fixed level or the 1,0,0,1 backpressure pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (bp_mode) begin
                out_ready = bp_pat[bp_k];
                bp_k      = (bp_k + 1) % 4;
            end else begin
                out_ready = or_level;
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset_n) begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            check("frame_cnt", 32'(frame_cnt), 32'(fc_model[15:0]));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(d_data), 32'(prev_d));
            end
            if (!out_valid) check("idle_last", 32'(out_last), 32'd0);
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("d_data", 32'(d_data), 32'(e.d));
                    check("out_last", 32'(out_last), 32'(e.last));
                    if (e.last) fc_model++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = d_data;
        end else begin
            prev_stall = 1'b0;
            fc_model   = 0;
            sb_q.delete();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        e_data   = 8'h00;
        key      = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d_data", 32'(d_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Round trip: one full frame through the encrypter model.
        for (int i = 0; i < 32; i++) send_plain();
        drain();
        check("rt_frame_cnt", 32'(frame_cnt), 32'd1);
        check("rt_frame_err", 32'(frame_err), 32'd0);

        // Known vector with latency: out_valid rises after the 5th edge
        // counting the accepting edge as the first.
        send_auto(8'h66, 8'h5A, 8'h3C);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(posedge clock);
            @(negedge clock);
            check("lat_valid", 32'(out_valid), 32'(c == 5));
        end
        check("kv1_data", 32'(d_data), 32'h3C);
        drain();
        send_auto(8'h00, 8'h00, 8'hFF);
        drain();
        for (int i = 0; i < 30; i++) send_plain();
        drain();
        check("kv_frame_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure: out_ready toggles 1,0,0,1 while streaming.
        bp_mode = 1;
        for (int i = 0; i < 32; i++) send_plain();
        bp_mode = 0;
        drain();
        check("bp_frame_cnt", 32'(frame_cnt), 32'd3);

        // Framing error: in_last on byte 5, then a correct frame.
        for (int i = 0; i < 32; i++) begin
            logic [7:0] d, k;
            d = 8'($urandom);
            k = 8'($urandom);
            if (i == 5) check("ferr_before", 32'(frame_err), 32'd0);
            send(enc(d, k), k, 1'(i == 5), d);
            if (i == 5) check("ferr_set", 32'(frame_err), 32'd1);
        end
        for (int i = 0; i < 32; i++) send_plain();
        drain();
        check("ferr_sticky", 32'(frame_err), 32'd1);
        check("ferr_frame_cnt", 32'(frame_cnt), 32'd5);

        // Reset mid-stream with 3 bytes in flight, S5 stalled.
        or_level = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) send_plain();
        repeat (2) @(posedge clock);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(d_data), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        tb_in_idx = 0;
        or_level  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 32; i++) send_plain();
        drain();
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        check("post_rst_frame_err", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
